bloon_wave_ctrl: RTL and testbench
==================================

// Module: bloon_wave_ctrl
// PURPOSE
//  Wave/lives controller that drives and consumes the per-bloon path interface
//  (startingTime, bloon_alive, bloonpause, reset in; lost_life and pop back out).
//  It schedules the spawn times for N bloon slots, starts, pauses and ends waves,
//  edge-detects leaks and pops, and keeps lives, score and wave number.
//  It sits between the top-level game FSM and the array of bloon path instances.
// PARAMETERS
//  N_BLOONS      8    bloon path slots per wave
//  TIME_W        128  width of each start time (path time unit = 2^20 Clk)
//  START_LIVES   100  lives loaded at reset
//  BASE_SPACING  64   spawn spacing of wave 0, in path time units
//  SPACING_STEP  8    spacing reduction per completed wave
//  MIN_SPACING   16   spacing floor
// PORTS
//  Clk            in   1               system clock
//  reset_n        in   1               async active-low reset
//  start_wave     in   1               level; sampled in IDLE/WAVE_DONE
//  pause_toggle   in   1               rising edge toggles pause in RUN
//  pop_i          in   N_BLOONS        per-slot pop (level, edge-detected)
//  lost_life_i    in   N_BLOONS        per-slot leak (held ~2^20 cycles; edge-detected)
//  path_reset_o   out  1               sync reset to all path instances
//  run_o          out  1               drives bloonpause (1 = paths advance)
//  slot_clear_o   out  N_BLOONS        drives bloon_alive (1 = slot held at 0)
//  start_time_o   out  N_BLOONS*TIME_W slot i at [i*TIME_W +: TIME_W]
//  lives_o        out  8               remaining lives (also feeds inputLives)
//  score_o        out  16              saturating pop count
//  wave_o         out  8               completed waves, saturates at 255
//  wave_active_o  out  1               state == RUN
//  game_over_o    out  1               state == GAME_OVER
// BEHAVIOUR
//  Reset (async, all outputs): IDLE; path_reset_o=1, run_o=0, slot_clear_o all 1,
//   start_time_o=0, lives_o=START_LIVES, score_o=0, wave_o=0, edge regs=0, paused=0.
//  Reset asserted mid-wave aborts immediately. No partial-wave state survives.
//  States:
//   IDLE/WAVE_DONE: path_reset_o=1, run_o=0. start_wave=1 -> LOAD.
//   LOAD (1 cycle): latch start_time[i] = i*spacing, where
//    spacing = max(BASE_SPACING - wave_o*SPACING_STEP, MIN_SPACING).
//    Compute in signed 16-bit. Zero-extend to TIME_W.
//    Clear slot_done and paused. path_reset_o stays 1. Next state is RUN.
//   RUN: path_reset_o=0, slot_clear_o=slot_done, run_o=~paused.
//   GAME_OVER: run_o=0, path_reset_o=0 (paths frozen); exit only via reset_n.
//  Edges: rise = x_i & ~x_q, with x_q registered every cycle in every state.
//   A rise counts only in RUN and only if ~slot_done[i].
//  Per RUN cycle:
//   pops  = popcount(pop_rise).
//   leaks = popcount(lost_rise & ~pop_rise). Pop wins a same-cycle tie on one slot.
//   slot_done |= pop_rise | lost_rise.
//   score_o += pops, saturating at 16'hFFFF.
//   lives_o = (lives_o > leaks) ? lives_o - leaks : 0.
//  Exit from RUN:
//   New lives == 0 -> GAME_OVER next cycle. This has priority over wave completion.
//   Else, if all slot_done (including this cycle) -> WAVE_DONE and wave_o += 1 (sat).
//  Pause: a pause_toggle rise in RUN flips paused. It is ignored in other states.
//   Leaks and pops are still counted while paused.
//  Latency: a leak or pop rise is reflected on lives_o/score_o 1 cycle later.
//   From start_wave sampled, run_o=1 follows 2 cycles later.
// STRUCTURE
//  bloon_pkg:
//   typedef enum {IDLE, LOAD, RUN, WAVE_DONE, GAME_OVER} wave_state_t;
//   constants LIVES_W=8, SCORE_W=16, PATH_TU_SHIFT=20;
//   popcount function.
//  Sub-module rise_det #(W): registered rising-edge detector, async active-low
//   reset. It is instantiated twice, for pop_i and lost_life_i.
// TESTING
//  1 Reset, start_wave=1 -> path_reset_o high through LOAD, then low.
//    Slot3 start_time=192. run_o=1 two cycles after start_wave.
//  2 lost_life_i[2] held 5000 cycles in RUN -> lives 100->99 exactly once.
//    slot_clear_o[2]=1.
//  3 pop_i[4] and lost_life_i[4] rise in the same cycle -> lives unchanged, score 0->1.
//  4 lives=2, lost_life_i[0,1,5] rise together -> lives 0, GAME_OVER.
//    run_o=0. A later start_wave is ignored.
//  5 All 8 slots popped -> WAVE_DONE, wave_o=1.
//    Next start_wave -> spacing 56, slot1 start_time=56.
//  6 pause_toggle rise -> run_o=0, second rise -> 1.
//    reset_n low mid-RUN without Clk -> all outputs at reset values immediately.

Source files
------------

// File: rtl/bloon_pkg.sv
// Shared types and helpers for the bloon wave/lives controller.
//   wave_state_t : controller states
//   LIVES_W, SCORE_W : widths of the lives and score counters
//   PATH_TU_SHIFT : log2 of Clk cycles per path time unit
//   popcount() : number of set bits in a vector of up to 32 bits
package bloon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    WAVE_DONE,
    GAME_OVER
  } wave_state_t;

  localparam int unsigned LIVES_W       = 8;
  localparam int unsigned SCORE_W       = 16;
  localparam int unsigned PATH_TU_SHIFT = 20;

  function automatic logic [7:0] popcount(input logic [31:0] v);
    logic [7:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      cnt = cnt + {7'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector.
//   Clk     : system clock
//   reset_n : async active-low reset, clears the history register
//   d       : W-bit level input
//   rise    : d & ~previous(d), combinational from the current input
module rise_det #(
  parameter int unsigned W = 1
) (
  input  logic         Clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] q;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  assign rise = d & ~q;

endmodule

// File: rtl/bloon_wave_ctrl.sv
// Wave/lives controller between the game FSM and the bloon path array.
// Schedules per-slot spawn times, starts/pauses/ends waves and tracks
// lives, score and completed waves from edge-detected pops and leaks.
//   Clk, reset_n   : clock, async active-low reset
//   start_wave     : level, starts a wave from IDLE/WAVE_DONE
//   pause_toggle   : rising edge toggles pause while a wave runs
//   pop_i          : per-slot pop level
//   lost_life_i    : per-slot leak level
//   path_reset_o   : sync reset to all path instances
//   run_o          : 1 = paths advance
//   slot_clear_o   : 1 = slot held at 0 (finished or not running)
//   start_time_o   : slot i spawn time at [i*TIME_W +: TIME_W]
//   lives_o        : remaining lives
//   score_o        : saturating pop count
//   wave_o         : completed waves, saturating
//   wave_active_o  : wave running
//   game_over_o    : no lives left
module bloon_wave_ctrl
  import bloon_pkg::*;
#(
  parameter int unsigned N_BLOONS     = 8,
  parameter int unsigned TIME_W       = 128,
  parameter int unsigned START_LIVES  = 100,
  parameter int unsigned BASE_SPACING = 64,
  parameter int unsigned SPACING_STEP = 8,
  parameter int unsigned MIN_SPACING  = 16
) (
  input  logic                         Clk,
  input  logic                         reset_n,
  input  logic                         start_wave,
  input  logic                         pause_toggle,
  input  logic [N_BLOONS-1:0]          pop_i,
  input  logic [N_BLOONS-1:0]          lost_life_i,
  output logic                         path_reset_o,
  output logic                         run_o,
  output logic [N_BLOONS-1:0]          slot_clear_o,
  output logic [N_BLOONS*TIME_W-1:0]   start_time_o,
  output logic [LIVES_W-1:0]           lives_o,
  output logic [SCORE_W-1:0]           score_o,
  output logic [7:0]                   wave_o,
  output logic                         wave_active_o,
  output logic                         game_over_o
);

  wave_state_t state, state_nx;

  logic [N_BLOONS-1:0] slot_done;
  logic [N_BLOONS-1:0] pop_rise_raw, lost_rise_raw;
  logic [N_BLOONS-1:0] pop_rise, lost_rise, leak_mask, done_nx;
  logic                paused, pause_q, pause_rise;
  logic                in_run;
  logic [7:0]          pops, leaks;
  logic [LIVES_W-1:0]  lives_nx;
  logic [SCORE_W:0]    score_sum;
  logic signed [15:0]  spacing_raw;
  logic [15:0]         spacing;

  rise_det #(.W(N_BLOONS)) u_pop_rise (
    .Clk     (Clk),
    .reset_n (reset_n),
    .d       (pop_i),
    .rise    (pop_rise_raw)
  );

  rise_det #(.W(N_BLOONS)) u_lost_rise (
    .Clk     (Clk),
    .reset_n (reset_n),
    .d       (lost_life_i),
    .rise    (lost_rise_raw)
  );

  assign pause_rise = pause_toggle & ~pause_q;

  // Signed arithmetic so late waves go negative and clamp to the floor.
  always_comb begin
    spacing_raw = $signed(16'(BASE_SPACING))
                - $signed({8'd0, wave_o}) * $signed(16'(SPACING_STEP));
    if (spacing_raw < $signed(16'(MIN_SPACING))) begin
      spacing = 16'(MIN_SPACING);
    end else begin
      spacing = spacing_raw;
    end
  end

  // Per-cycle accounting; a pop on a slot masks a same-cycle leak there.
  always_comb begin
    in_run    = (state == RUN);
    pop_rise  = in_run ? (pop_rise_raw & ~slot_done) : '0;
    lost_rise = in_run ? (lost_rise_raw & ~slot_done) : '0;
    leak_mask = lost_rise & ~pop_rise;
    pops      = popcount(32'(pop_rise));
    leaks     = popcount(32'(leak_mask));
    done_nx   = slot_done | pop_rise | lost_rise;
    lives_nx  = (lives_o > LIVES_W'(leaks)) ? (lives_o - LIVES_W'(leaks)) : '0;
    score_sum = {1'b0, score_o} + (SCORE_W + 1)'(pops);
  end

  always_comb begin
    state_nx      = state;
    path_reset_o  = 1'b0;
    run_o         = 1'b0;
    slot_clear_o  = '1;
    wave_active_o = 1'b0;
    game_over_o   = 1'b0;
    case (state)
      IDLE, WAVE_DONE: begin
        path_reset_o = 1'b1;
        if (start_wave) state_nx = LOAD;
      end
      LOAD: begin
        path_reset_o = 1'b1;
        state_nx     = RUN;
      end
      RUN: begin
        run_o         = ~paused;
        slot_clear_o  = slot_done;
        wave_active_o = 1'b1;
        if (lives_nx == '0) begin
          state_nx = GAME_OVER;
        end else if (&done_nx) begin
          state_nx = WAVE_DONE;
        end
      end
      GAME_OVER: begin
        slot_clear_o = slot_done;
        game_over_o  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      slot_done    <= '0;
      paused       <= 1'b0;
      pause_q      <= 1'b0;
      lives_o      <= LIVES_W'(START_LIVES);
      score_o      <= '0;
      wave_o       <= '0;
      start_time_o <= '0;
    end else begin
      state   <= state_nx;
      pause_q <= pause_toggle;
      case (state)
        LOAD: begin
          slot_done <= '0;
          paused    <= 1'b0;
          for (int unsigned i = 0; i < N_BLOONS; i++) begin
            start_time_o[i*TIME_W +: TIME_W] <=
              {{(TIME_W-16){1'b0}}, 16'(i) * spacing};
          end
        end
        RUN: begin
          slot_done <= done_nx;
          lives_o   <= lives_nx;
          score_o   <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          if (pause_rise) paused <= ~paused;
          if ((lives_nx != '0) && (&done_nx) && (wave_o != 8'hFF)) begin
            wave_o <= wave_o + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bloon_wave_ctrl.sv
module tb_bloon_wave_ctrl;

  logic         Clk;
  logic         reset_n;
  logic         start_wave;
  logic         pause_toggle;
  logic [7:0]   pop_i;
  logic [7:0]   lost_life_i;
  logic         path_reset_o;
  logic         run_o;
  logic [7:0]   slot_clear_o;
  logic [1023:0] start_time_o;
  logic [7:0]   lives_o;
  logic [15:0]  score_o;
  logic [7:0]   wave_o;
  logic         wave_active_o;
  logic         game_over_o;

  int total;
  int bad;

  logic [33:0] exp_q[$];
  string       name_q[$];

  bloon_wave_ctrl dut (
    .Clk           (Clk),
    .reset_n       (reset_n),
    .start_wave    (start_wave),
    .pause_toggle  (pause_toggle),
    .pop_i         (pop_i),
    .lost_life_i   (lost_life_i),
    .path_reset_o  (path_reset_o),
    .run_o         (run_o),
    .slot_clear_o  (slot_clear_o),
    .start_time_o  (start_time_o),
    .lives_o       (lives_o),
    .score_o       (score_o),
    .wave_o        (wave_o),
    .wave_active_o (wave_active_o),
    .game_over_o   (game_over_o)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Expected tuple {lives, score, wave, wave_active, game_over}
  function automatic logic [33:0] mk(input int l, input int s, input int w,
                                     input bit a, input bit g);
    return {8'(l), 16'(s), 8'(w), a, g};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic push(input string nm, input logic [33:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Pops one expected tuple whenever the observed tuple changes.
  task automatic monitor_loop();
    logic [33:0] prev, cur;
    prev = mk(100, 0, 0, 0, 0);
    forever begin
      @(negedge Clk);
      cur = {lives_o, score_o, wave_o, wave_active_o, game_over_o};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_change act=%0h req=none", cur);
        end else begin
          chk(name_q.pop_front(), cur, exp_q.pop_front());
        end
        prev = cur;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_path_reset"}, path_reset_o, 1);
    chk({tag, "_run"}, run_o, 0);
    chk({tag, "_slot_clear"}, slot_clear_o, 8'hFF);
    chk({tag, "_start_time"}, start_time_o[127:0] | start_time_o[255:128]
                              | start_time_o[1023:896], 0);
    chk({tag, "_lives"}, lives_o, 100);
    chk({tag, "_score"}, score_o, 0);
    chk({tag, "_wave"}, wave_o, 0);
    chk({tag, "_active"}, wave_active_o, 0);
    chk({tag, "_game_over"}, game_over_o, 0);
  endtask

  initial begin
    int lv, wv, sp;
    total = 0;
    bad = 0;
    fork
      monitor_loop();
    join_none
    start_wave   = 1'b0;
    pause_toggle = 1'b0;
    pop_i        = '0;
    lost_life_i  = '0;
    reset_n      = 1'b1;
    #1 reset_n   = 1'b0;
    #2;
    chk_reset_outputs("rst");
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Wave 0 start: LOAD keeps paths in reset, run follows two edges later
    start_wave = 1'b1;
    push("run_entry0", mk(100, 0, 0, 1, 0));
    tick();
    chk("load_path_reset", path_reset_o, 1);
    chk("load_run", run_o, 0);
    start_wave = 1'b0;
    tick();
    chk("run_path_reset", path_reset_o, 0);
    chk("run_run", run_o, 1);
    chk("w0_slot3_time", start_time_o[3*128 +: 128], 192);
    chk("w0_slot7_time", start_time_o[7*128 +: 128], 448);
    chk("w0_slot_clear", slot_clear_o, 8'h00);

    // Long-held leak counts once
    lost_life_i[2] = 1'b1;
    push("leak_slot2", mk(99, 0, 0, 1, 0));
    repeat (5000) tick();
    chk("leak_slot_clear", slot_clear_o, 8'h04);
    lost_life_i = '0;
    tick();

    // Pop wins a same-cycle tie with a leak
    pop_i[4] = 1'b1;
    lost_life_i[4] = 1'b1;
    push("tie_slot4", mk(99, 1, 0, 1, 0));
    tick();
    tick();
    chk("tie_slot_clear", slot_clear_o, 8'h14);
    pop_i = '0;
    lost_life_i = '0;
    tick();

    // All slots popped; already-finished slots 2 and 4 do not score
    pop_i = 8'hFF;
    push("wave0_done", mk(99, 7, 1, 0, 0));
    tick();
    tick();
    chk("wd_path_reset", path_reset_o, 1);
    chk("wd_slot_clear", slot_clear_o, 8'hFF);
    pop_i = '0;
    tick();

    // Wave 1: spacing 56
    start_wave = 1'b1;
    push("run_entry1", mk(99, 7, 1, 1, 0));
    tick();
    start_wave = 1'b0;
    tick();
    chk("w1_slot1_time", start_time_o[1*128 +: 128], 56);
    chk("w1_slot7_time", start_time_o[7*128 +: 128], 392);

    // Pause toggling; leaks still count while paused
    pause_toggle = 1'b1;
    tick();
    chk("pause_run_off", run_o, 0);
    lost_life_i[0] = 1'b1;
    push("leak_paused", mk(98, 7, 1, 1, 0));
    tick();
    tick();
    chk("pause_held", run_o, 0);
    pause_toggle = 1'b0;
    tick();
    chk("pause_fall", run_o, 0);
    pause_toggle = 1'b1;
    tick();
    chk("pause_run_on", run_o, 1);
    pause_toggle = 1'b0;
    lost_life_i = '0;
    tick();
    lost_life_i = 8'hFF;
    push("wave1_done", mk(91, 7, 2, 0, 0));
    tick();
    lost_life_i = '0;
    tick();

    // Full-leak waves walk lives down and spacing to its floor
    lv = 91;
    wv = 2;
    for (int k = 0; k < 11; k++) begin
      start_wave = 1'b1;
      push("loop_entry", mk(lv, 7, wv, 1, 0));
      tick();
      start_wave = 1'b0;
      tick();
      sp = (64 - 8 * wv < 16) ? 16 : 64 - 8 * wv;
      chk("loop_slot1_time", start_time_o[1*128 +: 128], 128'(sp));
      chk("loop_slot7_time", start_time_o[7*128 +: 128], 128'(7 * sp));
      lost_life_i = 8'hFF;
      push("loop_done", mk(lv - 8, 7, wv + 1, 0, 0));
      tick();
      lost_life_i = '0;
      tick();
      lv = lv - 8;
      wv = wv + 1;
    end

    // Final wave: lives 3 -> 2 -> 0, game over beats wave completion
    start_wave = 1'b1;
    push("final_entry", mk(3, 7, 13, 1, 0));
    tick();
    start_wave = 1'b0;
    tick();
    chk("final_slot1_time", start_time_o[1*128 +: 128], 16);
    pop_i = 8'h5C;
    push("final_pops", mk(3, 11, 13, 1, 0));
    tick();
    lost_life_i = 8'h80;
    push("final_leak7", mk(2, 11, 13, 1, 0));
    tick();
    lost_life_i = 8'hA3;
    push("game_over", mk(0, 11, 13, 0, 1));
    tick();
    chk("go_run", run_o, 0);
    chk("go_path_reset", path_reset_o, 0);
    chk("go_flag", game_over_o, 1);
    start_wave = 1'b1;
    repeat (3) tick();
    chk("go_sticky", game_over_o, 1);
    start_wave = 1'b0;
    pop_i = '0;
    lost_life_i = '0;

    // Reset out of game over, then async reset in the middle of a wave
    reset_n = 1'b0;
    push("go_reset", mk(100, 0, 0, 0, 0));
    tick();
    reset_n = 1'b1;
    tick();
    start_wave = 1'b1;
    push("rerun_entry", mk(100, 0, 0, 1, 0));
    tick();
    start_wave = 1'b0;
    tick();
    pop_i[0] = 1'b1;
    push("rerun_pop", mk(100, 1, 0, 1, 0));
    tick();
    pop_i = '0;
    tick();
    #2;
    reset_n = 1'b0;
    push("async_reset", mk(100, 0, 0, 0, 0));
    #1;
    chk_reset_outputs("async");
    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
